// File: rtl/gelato_ifetch.sv
// Instruction fetch: keeps one I-cache read in flight, then holds the returned word for decode; 1-cycle request latency.
// Decode backpressure (inst_ready=0) holds inst_* and blocks the next request; a redirect drains any in-flight read.
module gelato_ifetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  icache_valid,
    output logic [ADDR_WIDTH-1:0] icache_addr,
    input  logic                  icache_done,
    input  logic [DATA_WIDTH-1:0] icache_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, FETCH, OUTPUT, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic                  icache_valid_nxt;
    logic [ADDR_WIDTH-1:0] icache_addr_nxt;
    logic                  inst_valid_nxt;
    logic [ADDR_WIDTH-1:0] inst_pc_nxt;
    logic [DATA_WIDTH-1:0] inst_data_nxt;
    logic [ADDR_WIDTH-1:0] redirect_pc_al;
    logic [ADDR_WIDTH-1:0] pc_sel;

    assign redirect_pc_al = redirect_pc & ~ADDR_WIDTH'(3);
    // A request issued in the same cycle as a redirect already uses the new PC.
    assign pc_sel = redirect_valid ? redirect_pc_al : pc;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            icache_valid <= 1'b0;
            icache_addr  <= RESET_PC;
            inst_valid   <= 1'b0;
            inst_pc      <= '0;
            inst_data    <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            icache_valid <= icache_valid_nxt;
            icache_addr  <= icache_addr_nxt;
            inst_valid   <= inst_valid_nxt;
            inst_pc      <= inst_pc_nxt;
            inst_data    <= inst_data_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        pc_nxt           = redirect_valid ? redirect_pc_al : pc;
        icache_valid_nxt = icache_valid;
        icache_addr_nxt  = icache_addr;
        inst_valid_nxt   = inst_valid;
        inst_pc_nxt      = inst_pc;
        inst_data_nxt    = inst_data;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt        = FETCH;
                    icache_valid_nxt = 1'b1;
                    icache_addr_nxt  = pc_sel;
                end
            end

            FETCH: begin
                // FETCH with no request outstanding follows a completed or dropped read.
                if (!icache_valid) begin
                    icache_valid_nxt = 1'b1;
                    icache_addr_nxt  = pc_sel;
                end else if (redirect_valid) begin
                    if (icache_done) begin
                        icache_valid_nxt = 1'b0;
                        state_nxt        = enable ? FETCH : IDLE;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (icache_done) begin
                    inst_data_nxt    = icache_data;
                    inst_pc_nxt      = icache_addr;
                    inst_valid_nxt   = 1'b1;
                    pc_nxt           = pc + ADDR_WIDTH'(4);
                    icache_valid_nxt = 1'b0;
                    state_nxt        = OUTPUT;
                end
            end

            OUTPUT: begin
                if (redirect_valid || inst_ready) begin
                    inst_valid_nxt = 1'b0;
                    if (enable) begin
                        state_nxt        = FETCH;
                        icache_valid_nxt = 1'b1;
                        icache_addr_nxt  = pc_sel;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (icache_done) begin
                    icache_valid_nxt = 1'b0;
                    state_nxt        = enable ? FETCH : IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
